sample_delay_line: RTL and testbench

//  Programmable sample delay line built on a circular buffer in synchronous dual-port RAM.

---
 rtl/sample_delay_line_pkg.sv | 22 ++
 rtl/sample_delay_line_if.sv | 20 ++
 rtl/sample_delay_line_ram.sv | 33 +++
 rtl/sample_delay_line.sv | 118 +++++++++++
 tb/tb_sample_delay_line.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/sample_delay_line_pkg.sv
// sample_delay_pkg: shared types and helpers for the sample delay line.
//   sdl_stage_t  - one pipeline stage travelling beside the RAM read:
//                  input sample (bypass data), bypass/mask decisions, valid.
//   sdl_latency  - en-to-dout latency for a given OUT_REG setting.
// The stage data field is sized for the widest supported sample; narrower
// samples are zero-extended into it.
package sample_delay_pkg;

    localparam int SDL_MAX_DW = 32;

    typedef struct packed {
        logic [SDL_MAX_DW-1:0] data;
        logic                  bypass;
        logic                  mask;
        logic                  valid;
    } sdl_stage_t;

    function automatic int sdl_latency(input int out_reg);
        return (out_reg != 0) ? 2 : 1;
    endfunction

endpackage

// File: rtl/sample_delay_line_if.sv
// sample_delay_line_if: sample stream into and out of the delay line.
//   en         - sample strobe (din/delay accepted when 1)
//   delay      - delay in samples for the accepted sample
//   din        - input sample
//   dout       - delayed sample
//   dout_valid - 1-cycle pulse per accepted sample result
// master = sample source / consumer side, slave = delay line.
interface sample_delay_line_if #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8
);
    logic                     en;
    logic [ADDRESS_WIDTH-1:0] delay;
    logic [DATA_WIDTH-1:0]    din;
    logic [DATA_WIDTH-1:0]    dout;
    logic                     dout_valid;

    modport master (output en, delay, din, input dout, dout_valid);
    modport slave  (input en, delay, din, output dout, dout_valid);
endinterface

// File: rtl/sample_delay_line_ram.sv
// sdp_ram_core: simple dual-port RAM, one write port and one synchronous read
// port on the same clock. A read and a write to the same address in one cycle
// return the old word (read-before-write). Contents are never reset.
//   clk     - clock
//   wr_en   - write strobe, wr_addr/wr_data - write port
//   rd_en   - read strobe,  rd_addr         - read address
//   rd_data - registered read data, holds when rd_en=0
module sdp_ram_core #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);
    logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/sample_delay_line.sv
// sample_delay_line: programmable delay line on a circular RAM buffer.
// Every accepted sample is written at wr_ptr while the sample written `delay`
// accepted samples earlier is read. delay=0 bypasses the RAM; a delay longer
// than the number of samples written since reset yields zero, so stale RAM
// contents never reach the output.
//   clk, rst - clock, synchronous active-high reset (wins over en)
//   bus      - sample stream (slave side): en, delay, din in; dout, dout_valid out
// Latency from the en cycle: 1 (OUT_REG=0) or 2 (OUT_REG=1).
module sample_delay_line
    import sample_delay_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8,
    parameter int OUT_REG       = 0
) (
    input  logic                clk,
    input  logic                rst,
    sample_delay_line_if.slave  bus
);
    localparam int LATENCY = sdl_latency(OUT_REG);
    localparam logic [ADDRESS_WIDTH-1:0] FILL_MAX = '1;

    // Fill level counter saturates once the whole buffer holds real samples.
    function automatic logic [ADDRESS_WIDTH-1:0] sat_inc(input logic [ADDRESS_WIDTH-1:0] v);
        return (v == FILL_MAX) ? v : v + 1'b1;
    endfunction

    logic                     accept;
    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]    ram_rd_data;
    logic [DATA_WIDTH-1:0]    result;
    logic [DATA_WIDTH-1:0]    out_q, out_d;
    sdl_stage_t               st_p1_q, st_p1_d;

    // A sample arriving with rst is dropped entirely, including its RAM write.
    assign accept = bus.en & ~rst;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        fill_cnt_d = fill_cnt_q;
        rd_addr    = wr_ptr_q - bus.delay;
        st_p1_d        = '0;
        st_p1_d.data   = SDL_MAX_DW'(bus.din);
        st_p1_d.bypass = (bus.delay == '0);
        st_p1_d.mask   = (bus.delay > fill_cnt_q);
        st_p1_d.valid  = accept;
        if (accept) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            fill_cnt_d = sat_inc(fill_cnt_q);
        end
    end

    sdp_ram_core #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.din),
        .rd_en   (accept),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    // ---- stage p1: RAM word available, resolve bypass / mask ----
    always_comb begin
        if (st_p1_q.bypass) begin
            result = st_p1_q.data[DATA_WIDTH-1:0];
        end else if (st_p1_q.mask) begin
            result = '0;
        end else begin
            result = ram_rd_data;
        end
        out_d = st_p1_q.valid ? result : out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            st_p1_q    <= '0;
            out_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            st_p1_q    <= st_p1_d;
            out_q      <= out_d;
        end
    end

    generate
        if (DATA_WIDTH < SDL_MAX_DW) begin : g_pad
            logic unused_data_hi;
            assign unused_data_hi = ^st_p1_q.data[SDL_MAX_DW-1:DATA_WIDTH];
        end

        // ---- stage p2 (optional): registered output ----
        if (LATENCY == 2) begin : g_out_reg
            logic vld_p2_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p2_q <= 1'b0;
                end else begin
                    vld_p2_q <= st_p1_q.valid;
                end
            end
            assign bus.dout       = out_q;
            assign bus.dout_valid = vld_p2_q;
        end else begin : g_out_comb
            // out_q keeps the last result so dout holds between pulses.
            assign bus.dout       = out_d;
            assign bus.dout_valid = st_p1_q.valid;
        end
    endgenerate
endmodule

// File: tb/tb_sample_delay_line.sv
module tb_sample_delay_line;
    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int MAXD = (1 << AW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sample_delay_line_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    sample_delay_line_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    sample_delay_line #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    sample_delay_line #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: history of accepted samples since reset.
    int             n_acc;
    logic [DW-1:0]  hist[$];
    // Expected outputs of each DUT after the latest clock edge.
    logic           m0v, m1v;
    logic [DW-1:0]  m0d, m1d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_out(input int d, input logic [DW-1:0] x);
        int filled;
        filled = (n_acc < MAXD) ? n_acc : MAXD;
        if (d == 0) return x;
        if (d <= filled) return hist[hist.size() - d];
        return '0;
    endfunction

    // One clock: drive inputs, advance model at the edge, check both DUTs at the next negedge.
    task automatic step(input logic r, input logic e, input int d, input logic [DW-1:0] x, input string tag);
        logic [DW-1:0] res;
        rst = r;
        bus0.en = e; bus0.delay = AW'(d); bus0.din = x;
        bus1.en = e; bus1.delay = AW'(d); bus1.din = x;
        @(posedge clk);
        if (r) begin
            n_acc = 0; hist.delete();
            m0v = 1'b0; m0d = '0; m1v = 1'b0; m1d = '0;
        end else begin
            m1v = m0v; m1d = m0d;
            if (e) begin
                res = model_out(d, x);
                hist.push_back(x);
                if (hist.size() > MAXD + 1) void'(hist.pop_front());
                n_acc++;
                m0v = 1'b1; m0d = res;
            end else begin
                m0v = 1'b0;
            end
        end
        @(negedge clk);
        chk({tag, "_v0"}, 32'(bus0.dout_valid), 32'(m0v));
        chk({tag, "_d0"}, 32'(bus0.dout),       32'(m0d));
        chk({tag, "_v1"}, 32'(bus1.dout_valid), 32'(m1v));
        chk({tag, "_d1"}, 32'(bus1.dout),       32'(m1d));
    endtask

    initial begin
        bus0.en = 1'b0; bus0.delay = '0; bus0.din = '0;
        bus1.en = 1'b0; bus1.delay = '0; bus1.din = '0;
        n_acc = 0; m0v = 1'b0; m1v = 1'b0; m0d = '0; m1d = '0;
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, 0, 8'h00, "rst");
        chk("rst_dout0", 32'(bus0.dout), 32'h0);
        chk("rst_vld1",  32'(bus1.dout_valid), 32'h0);

        // Test 1 / 6: delay=3, din=1,2,3,...
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 3, 8'(i + 1), $sformatf("t1_s%0d", i));
            if (i == 0) chk("t1_s0_zero", 32'(bus0.dout), 32'h0);
            if (i == 3) chk("t1_s3_one",  32'(bus0.dout), 32'h1);
            if (i == 4) begin
                chk("t1_s4_two",   32'(bus0.dout), 32'h2);
                chk("t6_s3_lat2",  32'(bus1.dout), 32'h1);
            end
        end
        step(1'b0, 1'b0, 3, 8'h00, "t1_idle");

        // Test 2: bypass
        step(1'b0, 1'b1, 0, 8'hA5, "t2");
        chk("t2_bypass", 32'(bus0.dout), 32'hA5);
        step(1'b0, 1'b0, 0, 8'h00, "t2_idle");

        // Test 3: delay=15, din=n, pointer wrap and fill saturation
        step(1'b1, 1'b0, 0, 8'h00, "t3_rst");
        for (int i = 0; i <= 20; i++) begin
            step(1'b0, 1'b1, 15, 8'(i), $sformatf("t3_s%0d", i));
            if (i == 14) chk("t3_s14_mask", 32'(bus0.dout), 32'h0);
            if (i == 20) chk("t3_s20_five", 32'(bus0.dout), 32'h5);
        end

        // Test 4: en 1,0,0,1 with delay=1
        step(1'b1, 1'b0, 0, 8'h00, "t4_rst");
        step(1'b0, 1'b1, 1, 8'h07, "t4_a");
        step(1'b0, 1'b0, 1, 8'h00, "t4_b");
        chk("t4_hold_vld", 32'(bus0.dout_valid), 32'h0);
        step(1'b0, 1'b0, 1, 8'h00, "t4_c");
        step(1'b0, 1'b1, 1, 8'h09, "t4_d");
        chk("t4_second", 32'(bus0.dout), 32'h7);
        step(1'b0, 1'b0, 1, 8'h00, "t4_e");

        // Test 5: reset mid-stream (with en high: sample dropped), stale RAM masked
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1, 8'(8'h80 + i), "t5_fill");
        step(1'b1, 1'b1, 2, 8'hEE, "t5_rst");
        chk("t5_no_pulse", 32'(bus0.dout_valid), 32'h0);
        step(1'b0, 1'b1, 2, 8'h40, "t5_a");
        chk("t5_a_zero", 32'(bus0.dout), 32'h0);
        step(1'b0, 1'b1, 2, 8'h41, "t5_b");
        step(1'b0, 1'b1, 2, 8'h42, "t5_c");
        chk("t5_c_40", 32'(bus0.dout), 32'h40);
        step(1'b0, 1'b0, 2, 8'h00, "t5_idle");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
                 int'($urandom_range(0, MAXD)),
                 8'($urandom),
                 $sformatf("rnd%0d", i));
        end
        step(1'b0, 1'b0, 0, 8'h00, "tail0");
        step(1'b0, 1'b0, 0, 8'h00, "tail1");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
